// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch-PC generator and its redirect arbiter.
package pc_gen_pkg;

    localparam int unsigned PC_ADDR_W  = 32;
    localparam int unsigned PC_FETCH_W = 4;
    localparam logic [31:0] PC_ENTRY   = 32'h1c00_0000;

    typedef enum logic [1:0] {
        PcInit,
        PcRun,
        PcFlush
    } pc_state_e;

    // Width of a channel index; never zero so a single channel still gets a bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_redir_arb.sv
// Priority encoder over the redirect channels plus a one-entry pending slot that
// keeps the best redirect seen while fetch cannot take it.
module pc_redir_arb
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W  = PC_ADDR_W,
    parameter int unsigned REDIR_N = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      consume_i,
    input  logic [REDIR_N-1:0]        redir_valid_i,
    input  logic [REDIR_N*ADDR_W-1:0] redir_pc_i,
    input  logic [REDIR_N*ADDR_W-1:0] redir_old_pc_i,
    input  logic [REDIR_N-1:0]        redir_flush_all_i,
    output logic                      sel_valid_o,
    output logic [ADDR_W-1:0]         sel_pc_o,
    output logic [ADDR_W-1:0]         sel_old_pc_o,
    output logic                      sel_flush_all_o
);

    localparam int unsigned IDX_W = idx_width(REDIR_N);

    logic              fresh_valid;
    logic [IDX_W-1:0]  fresh_idx;
    logic [ADDR_W-1:0] fresh_pc;
    logic [ADDR_W-1:0] fresh_old_pc;
    logic              fresh_flush_all;
    logic              fresh_wins;

    logic              pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [ADDR_W-1:0] pend_old_pc_q, pend_old_pc_d;
    logic              pend_flush_all_q, pend_flush_all_d;

    // Scan from the top so the lowest asserted index is the last one written.
    always_comb begin
        fresh_valid     = 1'b0;
        fresh_idx       = '0;
        fresh_pc        = '0;
        fresh_old_pc    = '0;
        fresh_flush_all = 1'b0;
        for (int i = int'(REDIR_N) - 1; i >= 0; i--) begin
            if (redir_valid_i[i]) begin
                fresh_valid     = 1'b1;
                fresh_idx       = IDX_W'(i);
                fresh_pc        = redir_pc_i[i*ADDR_W +: ADDR_W];
                fresh_old_pc    = redir_old_pc_i[i*ADDR_W +: ADDR_W];
                fresh_flush_all = redir_flush_all_i[i];
            end
        end
    end

    assign fresh_wins = fresh_valid && (!pend_valid_q || (fresh_idx <= pend_idx_q));

    always_comb begin
        sel_valid_o     = fresh_valid || pend_valid_q;
        sel_pc_o        = pend_pc_q;
        sel_old_pc_o    = pend_old_pc_q;
        sel_flush_all_o = pend_flush_all_q;
        if (fresh_wins) begin
            sel_pc_o        = fresh_pc;
            sel_old_pc_o    = fresh_old_pc;
            sel_flush_all_o = fresh_flush_all;
        end
    end

    // Anything not consumed this cycle competes for the slot; losers are dropped.
    always_comb begin
        pend_valid_d     = pend_valid_q;
        pend_idx_d       = pend_idx_q;
        pend_pc_d        = pend_pc_q;
        pend_old_pc_d    = pend_old_pc_q;
        pend_flush_all_d = pend_flush_all_q;
        if (clear_i || consume_i) begin
            pend_valid_d = 1'b0;
        end else if (fresh_wins) begin
            pend_valid_d     = 1'b1;
            pend_idx_d       = fresh_idx;
            pend_pc_d        = fresh_pc;
            pend_old_pc_d    = fresh_old_pc;
            pend_flush_all_d = fresh_flush_all;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q     <= 1'b0;
            pend_idx_q       <= '0;
            pend_pc_q        <= '0;
            pend_old_pc_q    <= '0;
            pend_flush_all_q <= 1'b0;
        end else begin
            pend_valid_q     <= pend_valid_d;
            pend_idx_q       <= pend_idx_d;
            pend_pc_q        <= pend_pc_d;
            pend_old_pc_q    <= pend_old_pc_d;
            pend_flush_all_q <= pend_flush_all_d;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: aligned sequential fetch groups, prioritised redirects with
// a one-cycle icache flush, and a global restart to ENTRY.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W     = PC_ADDR_W,
    parameter int unsigned       FETCH_W    = PC_FETCH_W,
    parameter int unsigned       INST_BYTES = 4,
    parameter int unsigned       REDIR_N    = 3,
    parameter logic [ADDR_W-1:0] ENTRY      = ADDR_W'(PC_ENTRY)
) (
    input  logic                      Clk,
    input  logic                      Rest,
    input  logic                      PcFlash,
    input  logic                      PcStop,
    input  logic [REDIR_N-1:0]        RedirValid,
    input  logic [REDIR_N*ADDR_W-1:0] RedirPc,
    input  logic [REDIR_N*ADDR_W-1:0] RedirOldPc,
    input  logic [REDIR_N-1:0]        RedirFlushAll,
    output logic                      FetchValid,
    input  logic                      FetchReady,
    output logic [ADDR_W-1:0]         FetchPc,
    output logic [FETCH_W-1:0]        FetchMask,
    output logic                      IcacheFlash,
    output logic                      IcacheFlashAll,
    output logic [ADDR_W-1:0]         IcacheFlashEnty
);

    localparam int unsigned       GRP_B    = FETCH_W * INST_BYTES;
    localparam int unsigned       IB_W     = $clog2(INST_BYTES);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(GRP_B - 1);

    pc_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [FETCH_W-1:0] mask_q, mask_d;
    logic               flash_q, flash_d;
    logic               flash_all_q, flash_all_d;
    logic [ADDR_W-1:0]  enty_q, enty_d;

    logic               consume;
    logic               fetch_fire;
    logic [ADDR_W-1:0]  grp_next;
    logic               sel_valid;
    logic [ADDR_W-1:0]  sel_pc;
    logic [ADDR_W-1:0]  sel_old_pc;
    logic               sel_flush_all;

    // Slots before the PC's position within its group are not part of this fetch.
    function automatic logic [FETCH_W-1:0] mask_of(input logic [ADDR_W-1:0] pc);
        logic [ADDR_W-1:0]  slot;
        logic [FETCH_W-1:0] m;
        m    = '0;
        slot = (pc & OFF_MASK) >> IB_W;
        for (int i = 0; i < int'(FETCH_W); i++) begin
            m[i] = (ADDR_W'(i) >= slot);
        end
        return m;
    endfunction

    pc_redir_arb #(
        .ADDR_W  (ADDR_W),
        .REDIR_N (REDIR_N)
    ) u_redir_arb (
        .clk_i             (Clk),
        .rst_ni            (Rest),
        .clear_i           (PcFlash),
        .consume_i         (consume),
        .redir_valid_i     (RedirValid),
        .redir_pc_i        (RedirPc),
        .redir_old_pc_i    (RedirOldPc),
        .redir_flush_all_i (RedirFlushAll),
        .sel_valid_o       (sel_valid),
        .sel_pc_o          (sel_pc),
        .sel_old_pc_o      (sel_old_pc),
        .sel_flush_all_o   (sel_flush_all)
    );

    assign FetchValid = (state_q == PcRun) && !PcStop;
    assign fetch_fire = FetchValid && FetchReady;
    assign grp_next   = (pc_q & ~OFF_MASK) + ADDR_W'(GRP_B);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flash_d     = 1'b0;
        flash_all_d = 1'b0;
        enty_d      = '0;
        consume     = 1'b0;
        if (PcFlash) begin
            state_d     = PcInit;
            pc_d        = ENTRY;
            flash_all_d = 1'b1;
        end else begin
            unique case (state_q)
                PcInit: state_d = PcRun;
                PcRun, PcFlush: begin
                    state_d = PcRun;
                    // A redirect overrides the sequential step even if the group was accepted.
                    if (!PcStop && sel_valid) begin
                        state_d     = PcFlush;
                        pc_d        = sel_pc;
                        consume     = 1'b1;
                        flash_all_d = sel_flush_all;
                        flash_d     = !sel_flush_all;
                        enty_d      = sel_flush_all ? '0 : sel_old_pc;
                    end else if (fetch_fire) begin
                        pc_d = grp_next;
                    end
                end
                default: state_d = PcInit;
            endcase
        end
    end

    always_comb begin
        mask_d = mask_of(pc_d);
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_q     <= PcInit;
            pc_q        <= ENTRY;
            mask_q      <= mask_of(ENTRY);
            flash_q     <= 1'b0;
            flash_all_q <= 1'b1;
            enty_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mask_q      <= mask_d;
            flash_q     <= flash_d;
            flash_all_q <= flash_all_d;
            enty_q      <= enty_d;
        end
    end

    assign FetchPc         = pc_q;
    assign FetchMask       = mask_q;
    assign IcacheFlash     = flash_q;
    assign IcacheFlashAll  = flash_all_q;
    assign IcacheFlashEnty = enty_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a cycle-level reference model checked every cycle,
// plus hand-computed expectations along the scripted scenarios.
module tb_pc_gen;

    localparam int unsigned AW    = 32;
    localparam int unsigned FW    = 4;
    localparam int unsigned IB    = 4;
    localparam int unsigned NR    = 3;
    localparam int unsigned GRP   = FW * IB;
    localparam logic [31:0] ENTRY = 32'h1c00_0000;
    localparam int P_INIT  = 0;
    localparam int P_RUN   = 1;
    localparam int P_FLUSH = 2;

    logic              Clk;
    logic              Rest;
    logic              PcFlash;
    logic              PcStop;
    logic [NR-1:0]     RedirValid;
    logic [NR*AW-1:0]  RedirPc;
    logic [NR*AW-1:0]  RedirOldPc;
    logic [NR-1:0]     RedirFlushAll;
    logic              FetchValid;
    logic              FetchReady;
    logic [AW-1:0]     FetchPc;
    logic [FW-1:0]     FetchMask;
    logic              IcacheFlash;
    logic              IcacheFlashAll;
    logic [AW-1:0]     IcacheFlashEnty;

    int n_cmp = 0;
    int n_bad = 0;

    pc_gen #(
        .ADDR_W     (AW),
        .FETCH_W    (FW),
        .INST_BYTES (IB),
        .REDIR_N    (NR),
        .ENTRY      (ENTRY)
    ) dut (
        .Clk             (Clk),
        .Rest            (Rest),
        .PcFlash         (PcFlash),
        .PcStop          (PcStop),
        .RedirValid      (RedirValid),
        .RedirPc         (RedirPc),
        .RedirOldPc      (RedirOldPc),
        .RedirFlushAll   (RedirFlushAll),
        .FetchValid      (FetchValid),
        .FetchReady      (FetchReady),
        .FetchPc         (FetchPc),
        .FetchMask       (FetchMask),
        .IcacheFlash     (IcacheFlash),
        .IcacheFlashAll  (IcacheFlashAll),
        .IcacheFlashEnty (IcacheFlashEnty)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_phase;
    logic [31:0] m_pc;
    bit          m_flash;
    bit          m_all;
    logic [31:0] m_enty;
    int          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_pend_old;
    bit          m_pend_all;

    int          w;
    bit          fresh_beats;
    bit          c_hit;
    logic [31:0] c_pc;
    logic [31:0] c_old;
    bit          c_all;

    always_comb begin
        w = -1;
        for (int i = NR - 1; i >= 0; i--) begin
            if (RedirValid[i]) w = i;
        end
        fresh_beats = (w >= 0) && ((m_pend < 0) || (w <= m_pend));
        c_hit = fresh_beats || (m_pend >= 0);
        c_pc  = m_pend_pc;
        c_old = m_pend_old;
        c_all = m_pend_all;
        if (fresh_beats) begin
            c_pc  = RedirPc[w*AW +: AW];
            c_old = RedirOldPc[w*AW +: AW];
            c_all = RedirFlushAll[w];
        end
    end

    always @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            m_phase <= P_INIT;
            m_pc    <= ENTRY;
            m_flash <= 1'b0;
            m_all   <= 1'b1;
            m_enty  <= '0;
            m_pend  <= -1;
        end else begin
            m_flash <= 1'b0;
            m_all   <= 1'b0;
            m_enty  <= '0;
            if (PcFlash) begin
                m_phase <= P_INIT;
                m_pc    <= ENTRY;
                m_all   <= 1'b1;
                m_pend  <= -1;
            end else if (m_phase == P_INIT || PcStop) begin
                m_phase <= P_RUN;
                if (fresh_beats) begin
                    m_pend     <= w;
                    m_pend_pc  <= c_pc;
                    m_pend_old <= c_old;
                    m_pend_all <= c_all;
                end
            end else if (c_hit) begin
                m_phase <= P_FLUSH;
                m_pc    <= c_pc;
                m_all   <= c_all;
                m_flash <= !c_all;
                m_enty  <= c_all ? 32'h0 : c_old;
                m_pend  <= -1;
            end else begin
                m_phase <= P_RUN;
                if (m_phase == P_RUN && FetchReady) m_pc <= (m_pc / GRP + 1) * GRP;
            end
        end
    end

    function automatic logic [FW-1:0] exp_mask(input logic [31:0] pc);
        int unsigned   slot;
        logic [FW-1:0] m;
        slot = (pc % GRP) / IB;
        m = 4'hf << slot;
        return m;
    endfunction

    always @(negedge Clk) begin
        chk("model_valid", 32'(FetchValid), 32'((m_phase == P_RUN) && !PcStop));
        chk("model_pc", FetchPc, m_pc);
        chk("model_mask", 32'(FetchMask), 32'(exp_mask(m_pc)));
        chk("model_flash", 32'(IcacheFlash), 32'(m_flash));
        chk("model_flash_all", 32'(IcacheFlashAll), 32'(m_all));
        chk("model_enty", IcacheFlashEnty, m_enty);
        chk("flash_exclusive", 32'(IcacheFlash && IcacheFlashAll), 32'h0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic look();
        @(negedge Clk);
    endtask

    task automatic redir(input int ch, input logic [31:0] pc, input logic [31:0] old,
                         input bit all);
        RedirValid[ch]          = 1'b1;
        RedirPc[ch*AW +: AW]    = pc;
        RedirOldPc[ch*AW +: AW] = old;
        RedirFlushAll[ch]       = all;
    endtask

    initial begin
        Rest = 1'b0; PcFlash = 1'b0; PcStop = 1'b0; FetchReady = 1'b1;
        RedirValid = '0; RedirPc = '0; RedirOldPc = '0; RedirFlushAll = '0;
        #12;
        chk("rst_valid", 32'(FetchValid), 32'h0);
        chk("rst_flash_all", 32'(IcacheFlashAll), 32'h1);
        chk("rst_flash", 32'(IcacheFlash), 32'h0);
        chk("rst_pc", FetchPc, 32'h1c00_0000);
        chk("rst_mask", 32'(FetchMask), 32'hf);
        tick(); Rest = 1'b1;
        look(); chk("init_flash_all", 32'(IcacheFlashAll), 32'h1);
        chk("init_valid", 32'(FetchValid), 32'h0);
        tick(); look(); chk("seq0_pc", FetchPc, 32'h1c00_0000);
        chk("seq0_valid", 32'(FetchValid), 32'h1);
        chk("seq0_flash_all", 32'(IcacheFlashAll), 32'h0);
        tick(); look(); chk("seq1_pc", FetchPc, 32'h1c00_0010);
        tick(); look(); chk("seq2_pc", FetchPc, 32'h1c00_0020);
        chk("seq2_mask", 32'(FetchMask), 32'hf);

        // Channels 0 and 1 together: channel 0 (full flush) wins.
        tick(); redir(0, 32'h1c00_0100, 32'h0, 1'b1); redir(1, 32'h1c00_0200, 32'h0, 1'b0);
        tick(); RedirValid = '0;
        look(); chk("prio_flush_valid", 32'(FetchValid), 32'h0);
        chk("prio_flush_all", 32'(IcacheFlashAll), 32'h1);
        chk("prio_flash", 32'(IcacheFlash), 32'h0);
        tick(); look(); chk("prio_pc", FetchPc, 32'h1c00_0100);
        chk("prio_valid", 32'(FetchValid), 32'h1);

        // Selective flush into the middle of a group.
        tick(); redir(2, 32'h1c00_0108, 32'h1c00_0040, 1'b0);
        tick(); RedirValid = '0;
        look(); chk("sel_flash", 32'(IcacheFlash), 32'h1);
        chk("sel_flash_all", 32'(IcacheFlashAll), 32'h0);
        chk("sel_enty", IcacheFlashEnty, 32'h1c00_0040);
        tick(); look(); chk("sel_pc", FetchPc, 32'h1c00_0108);
        chk("sel_mask", 32'(FetchMask), 32'hc);
        tick(); look(); chk("sel_next_pc", FetchPc, 32'h1c00_0110);
        chk("sel_next_mask", 32'(FetchMask), 32'hf);

        // Stop for five cycles with redirects ch2, ch1, ch2: ch1 must survive.
        tick(); PcStop = 1'b1; redir(2, 32'h1c00_0300, 32'h0, 1'b1);
        look(); chk("stop_valid0", 32'(FetchValid), 32'h0);
        tick(); RedirValid = '0; redir(1, 32'h1c00_0400, 32'h1c00_0080, 1'b0);
        look(); chk("stop_valid1", 32'(FetchValid), 32'h0);
        tick(); RedirValid = '0; redir(2, 32'h1c00_0500, 32'h0, 1'b1);
        look(); chk("stop_valid2", 32'(FetchValid), 32'h0);
        tick(); RedirValid = '0;
        look(); chk("stop_valid3", 32'(FetchValid), 32'h0);
        tick(); look(); chk("stop_valid4", 32'(FetchValid), 32'h0);
        chk("stop_pc_held", FetchPc, 32'h1c00_0120);
        tick(); PcStop = 1'b0;
        look(); chk("release_valid", 32'(FetchValid), 32'h1);
        tick(); look(); chk("pend_flush_valid", 32'(FetchValid), 32'h0);
        chk("pend_pc", FetchPc, 32'h1c00_0400);
        chk("pend_flash", 32'(IcacheFlash), 32'h1);
        chk("pend_enty", IcacheFlashEnty, 32'h1c00_0080);
        tick(); look(); chk("pend_run_pc", FetchPc, 32'h1c00_0400);
        chk("pend_run_valid", 32'(FetchValid), 32'h1);

        // Backpressure: PC and mask stay put while not ready.
        tick(); FetchReady = 1'b0;
        look(); chk("hold_pc0", FetchPc, 32'h1c00_0410);
        tick(); look(); chk("hold_pc1", FetchPc, 32'h1c00_0410);
        tick(); look(); chk("hold_pc2", FetchPc, 32'h1c00_0410);
        chk("hold_mask", 32'(FetchMask), 32'hf);
        tick(); FetchReady = 1'b1;
        look(); chk("hold_pc3", FetchPc, 32'h1c00_0410);
        tick(); look(); chk("hold_adv", FetchPc, 32'h1c00_0420);

        // Top-of-space group wraps to zero.
        tick(); redir(0, 32'hffff_fff0, 32'h0, 1'b1);
        tick(); RedirValid = '0;
        look(); chk("wrap_flush_pc", FetchPc, 32'hffff_fff0);
        tick(); look(); chk("wrap_pc", FetchPc, 32'hffff_fff0);
        tick(); look(); chk("wrap_zero", FetchPc, 32'h0000_0000);

        // Stop during FLUSH parks a redirect; restart must discard it.
        tick(); redir(0, 32'h1c00_0700, 32'h0, 1'b1);
        tick(); RedirValid = '0; PcStop = 1'b1; redir(1, 32'h1c00_0800, 32'h0, 1'b1);
        look(); chk("f6_flush_all", 32'(IcacheFlashAll), 32'h1);
        chk("f6_pc", FetchPc, 32'h1c00_0700);
        tick(); RedirValid = '0; PcFlash = 1'b1;
        look(); chk("f6_pulse_one", 32'(IcacheFlashAll), 32'h0);
        chk("f6_stopped", 32'(FetchValid), 32'h0);
        tick(); PcFlash = 1'b0; PcStop = 1'b0;
        look(); chk("f6_init_all", 32'(IcacheFlashAll), 32'h1);
        chk("f6_init_pc", FetchPc, 32'h1c00_0000);
        chk("f6_init_valid", 32'(FetchValid), 32'h0);
        tick(); look(); chk("f6_run_pc", FetchPc, 32'h1c00_0000);
        chk("f6_no_pend", 32'(IcacheFlash | IcacheFlashAll), 32'h0);
        tick(); look(); chk("f6_seq_pc", FetchPc, 32'h1c00_0010);

        // Fresh higher-priority redirect on release beats the pending one.
        tick(); PcStop = 1'b1; redir(2, 32'h1c00_0900, 32'h0, 1'b1);
        tick(); RedirValid = '0; PcStop = 1'b0; redir(1, 32'h1c00_0a00, 32'h0, 1'b1);
        tick(); RedirValid = '0;
        look(); chk("fresh_pc", FetchPc, 32'h1c00_0a00);
        tick(); look(); chk("fresh_run_pc", FetchPc, 32'h1c00_0a00);
        chk("fresh_run_valid", 32'(FetchValid), 32'h1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
